// File: rtl/pin_bank_pkg.sv
// pin_bank_pkg: shared constants, types and helpers for the pin_bank IO bank.
//   MAX_WIDTH   - largest supported pin count
//   MIN_SYNC    - shallowest synchroniser allowed
//   edge_mode_e - per-pin edge interrupt mode (used by stimulus code)
//   clog2_sat   - $clog2 that never returns less than 1, so counters are
//                 always at least one bit wide
package pin_bank_pkg;

   localparam int MAX_WIDTH = 32;
   localparam int MIN_SYNC  = 2;

   typedef enum logic [1:0] {
      EDGE_NONE,
      EDGE_RISE,
      EDGE_FALL,
      EDGE_BOTH
   } edge_mode_e;

   function automatic int clog2_sat(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/pin_bank_if.sv
// pin_bank_if: register-side bus of the pin_bank IO bank.
//   dir_wr_en/dir_wr_data  - direction register write (1 = drive)
//   out_wr_en/out_wr_data  - output latch write
//   rise_en/fall_en        - per-pin edge interrupt enables
//   irq_clr                - write-1-to-clear strobe for irq_status
//   data_read              - synchronised (optionally debounced) pin values
//   irq_status/irq         - sticky edge status and its OR-reduction
// master: the stimulus source or bus bridge; slave: pin_bank.
interface pin_bank_if
   import pin_bank_pkg::*;
#(
   parameter int WIDTH = 8
);

   logic             dir_wr_en;
   logic [WIDTH-1:0] dir_wr_data;
   logic             out_wr_en;
   logic [WIDTH-1:0] out_wr_data;
   logic [WIDTH-1:0] rise_en;
   logic [WIDTH-1:0] fall_en;
   logic [WIDTH-1:0] irq_clr;
   logic [WIDTH-1:0] data_read;
   logic [WIDTH-1:0] irq_status;
   logic             irq;

   modport master (
      output dir_wr_en, dir_wr_data, out_wr_en, out_wr_data,
             rise_en, fall_en, irq_clr,
      input  data_read, irq_status, irq
   );

   modport slave (
      input  dir_wr_en, dir_wr_data, out_wr_en, out_wr_data,
             rise_en, fall_en, irq_clr,
      output data_read, irq_status, irq
   );

endinterface

// File: rtl/pin_sync.sv
// pin_sync: one-bit input synchroniser chain with optional debounce filter.
//   clk, rst - clock and synchronous active-high reset
//   din      - asynchronous pin value
//   dout     - synchronised value (debounced when PIN_BANK_DEBOUNCE_EN is
//              defined; otherwise the last synchroniser stage)
// Optional feature macro: PIN_BANK_DEBOUNCE_EN.
module pin_sync
   import pin_bank_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout
);

   logic [SYNC_STAGES-1:0] sync_p;

   // synchroniser stages: sync_p[0] is the metastable capture flop
   always_ff @(posedge clk) begin
      if (rst) sync_p <= '0;
      else     sync_p <= {sync_p[SYNC_STAGES-2:0], din};
   end

`ifdef PIN_BANK_DEBOUNCE_EN
   localparam int               CNT_W    = clog2_sat(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [CNT_W-1:0] cnt;
   logic             filt;

   // debounce stage: the filtered value follows only after DEBOUNCE_CYCLES
   // consecutive disagreeing samples; any agreeing sample restarts the count
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt  <= '0;
         filt <= 1'b0;
      end else if (sync_p[SYNC_STAGES-1] == filt) begin
         cnt <= '0;
      end else if (cnt == CNT_LAST) begin
         filt <= sync_p[SYNC_STAGES-1];
         cnt  <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign dout = filt;
`else
   assign dout = sync_p[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/pin_bank.sv
// pin_bank: WIDTH-pin bidirectional IO bank with per-pin direction, output
// latch, input synchronisation and sticky rising/falling edge interrupts.
//   clk, rst - clock and synchronous active-high reset
//   bus      - pin_bank_if.slave register bus (writes, enables, status)
//   io_port  - physical inout pins, driven only where dir is 1
// Optional feature macro: PIN_BANK_DEBOUNCE_EN (per-pin debounce filter in
// pin_sync ahead of data_read and edge detection).
module pin_bank
   import pin_bank_pkg::*;
#(
   parameter int WIDTH           = 8,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic             clk,
   input  logic             rst,
   pin_bank_if.slave        bus,
   inout  wire  [WIDTH-1:0] io_port
);

   localparam int                WARM_W   = clog2_sat(SYNC_STAGES + 2);
   localparam logic [WARM_W-1:0] WARM_MAX = WARM_W'(SYNC_STAGES + 1);

   logic [WIDTH-1:0]  dir_q;
   logic [WIDTH-1:0]  out_q;
   logic [WIDTH-1:0]  data_p;
   logic [WIDTH-1:0]  prev_p;
   logic [WIDTH-1:0]  status_q;
   logic [WIDTH-1:0]  rise;
   logic [WIDTH-1:0]  fall;
   logic [WARM_W-1:0] warm_cnt;
   logic              warm;

   always_ff @(posedge clk) begin
      if (rst) begin
         dir_q <= '0;
         out_q <= '0;
      end else begin
         if (bus.dir_wr_en) dir_q <= bus.dir_wr_data;
         if (bus.out_wr_en) out_q <= bus.out_wr_data;
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_pin
      assign io_port[i] = dir_q[i] ? out_q[i] : 1'bz;

      pin_sync #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_sync (
         .clk  (clk),
         .rst  (rst),
         .din  (io_port[i]),
         .dout (data_p[i])
      );
   end

   // edge stage: compare current read value against the one from last cycle
   assign rise = data_p & ~prev_p;
   assign fall = ~data_p & prev_p;

   // Edge detection stays off until the synchroniser has flushed its reset
   // zeros, so a pin already high at reset exit does not look like a rise.
   assign warm = (warm_cnt == WARM_MAX);

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_p   <= '0;
         warm_cnt <= '0;
         status_q <= '0;
      end else begin
         prev_p <= data_p;
         if (!warm) warm_cnt <= warm_cnt + 1'b1;
         // set terms are ORed after the clear, so a same-cycle set wins
         status_q <= (status_q & ~bus.irq_clr)
                   | (warm ? ((rise & bus.rise_en) | (fall & bus.fall_en)) : '0);
      end
   end

   assign bus.data_read  = data_p;
   assign bus.irq_status = status_q;
   assign bus.irq        = |status_q;

endmodule

// File: doc/pin_bank.md
Name: pin_bank

Overview:
- Parametrised multi-pin bidirectional IO bank: WIDTH pins, each with its own direction bit and output latch.
- Inputs pass through a SYNC_STAGES-deep synchroniser and feed per-pin rising/falling edge detection.
- Edges set sticky, write-1-to-clear interrupt status bits, which are ORed into one irq line.
- Sits between SST-driven test stimulus (or a bus bridge) and the physical inout pins.

Parameters:
- WIDTH, 8, number of pins (1..32).
- SYNC_STAGES, 2, input synchroniser depth (2..4).
- DEBOUNCE_CYCLES, 4, consecutive stable samples required by the optional debounce filter (1..255).

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- dir_wr_en  in  1  load dir register from dir_wr_data.
- dir_wr_data  in  WIDTH  1 = drive pin, 0 = input (high-Z).
- out_wr_en  in  1  load output latch from out_wr_data.
- out_wr_data  in  WIDTH  values to drive.
- io_port  inout  WIDTH  physical pins.
- data_read  out  WIDTH  synchronised (optionally debounced) pin values.
- rise_en  in  WIDTH  per-pin rising-edge interrupt enable.
- fall_en  in  WIDTH  per-pin falling-edge interrupt enable.
- irq_clr  in  WIDTH  write-1-to-clear status, one-cycle strobe.
- irq_status  out  WIDTH  sticky edge status.
- irq  out  1  OR-reduction of irq_status.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - dir = 0 (all pins high-Z); out latch = 0.
  - All sync flops and prev = 0; data_read = 0.
  - irq_status = 0; irq = 0.
  - warm-up counter = 0.
  - Reset asserted mid-operation takes effect at the next posedge: pins release to Z in the following cycle and pending status is lost.
- Output path:
  - io_port[i] = dir[i] ? out[i] : 1'bz.
  - dir and out are registered. A write at edge N appears on the pin after edge N.
  - dir_wr_en and out_wr_en in the same cycle are both applied.
- Input path:
  - io_port feeds a SYNC_STAGES flop chain; data_read = last stage.
  - A pin change before edge T is visible on data_read after edge T+SYNC_STAGES-1.
  - A driven pin reads back its own output value (loopback).
- Edge detection:
  - prev register holds the previous data_read.
  - rise[i] = data_read[i] & ~prev[i]; fall[i] = ~data_read[i] & prev[i].
- Warm-up:
  - A counter runs 0..SYNC_STAGES+1 after reset and saturates.
  - Edge detection is suppressed until it saturates, so no spurious edges at reset exit.
- Status update, per pin, each edge: status <= (status & ~irq_clr) | (rise & rise_en) | (fall & fall_en).
  - Set and clear in the same cycle: set wins.
  - Enables are sampled in the same cycle as the edge. Disabling an enable does not clear status already set.
- irq = |irq_status, combinational from the registered status. irq rises the same cycle status sets.
- Width rules:
  - All vectors are exactly WIDTH bits.
  - The warm-up counter is $clog2(SYNC_STAGES+2) bits.

Optional Feature:
- Macro: PIN_BANK_DEBOUNCE_EN.
- Defined:
  - Each pin gets a counter of $clog2(DEBOUNCE_CYCLES+1) bits.
  - The filtered value updates to the synchronised value only after it differs from the filtered value for DEBOUNCE_CYCLES consecutive cycles. Any return to the filtered value zeroes the counter.
  - data_read and edge detection use the filtered value.
  - Added latency is DEBOUNCE_CYCLES cycles.
  - Filters and counters reset to 0.
- Undefined: filtered = synchronised value; no counters instantiated.

Decomposition:
- Package pin_bank_pkg holds:
  - MAX_WIDTH = 32, MIN_SYNC = 2;
  - typedef edge_mode_e {EDGE_NONE, EDGE_RISE, EDGE_FALL, EDGE_BOTH}, for bench use;
  - function clog2_sat.
- One sub-module: pin_sync, a parametrised per-bit synchroniser chain plus optional debounce filter, instantiated once per pin via generate.

Test Plan:
1. Reset then dir=8'hFF, out=8'hA5 written at edge N -> io_port=8'hA5 after edge N. With the bench releasing pins, data_read=8'hA5 after edge N+2. No irq during warm-up.
2. dir=0, bench drives io_port 8'h00->8'h01 with rise_en=8'h01 -> data_read[0]=1 two edges later, irq_status=8'h01 and irq=1 one edge after that.
3. fall_en=8'h80, bench drives bit7 1->0 while irq_clr[7] is pulsed in the same cycle the edge is detected -> irq_status[7] stays 1 (set wins). A following irq_clr=8'h80 clears it to 0 and irq drops.
4. Pins toggled with rise_en=fall_en=0 -> irq_status stays 8'h00. Enabling afterwards raises nothing until a new edge.
5. Assert rst while dir=8'hFF and irq_status=8'h0F -> after that edge io_port=Z, irq_status=0, irq=0. A pin held at 1 through reset exit produces no rising edge.
6. With PIN_BANK_DEBOUNCE_EN, DEBOUNCE_CYCLES=4, a 3-cycle glitch on bit2 -> data_read unchanged, no status. A 5-cycle level -> data_read[2] updates 4 cycles after synchronisation.
